// File: rtl/vuprs_adc_regs_pkg.sv
// Shared types and constants for the VUPRS ADC AXI4-Lite register file.
package vuprs_adc_regs_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         MAX_REGS    = 256;

  typedef enum logic [1:0] {ACC_RW, ACC_RO, ACC_W1C} acc_t;

  typedef enum logic [2:0] {
    WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_COMMIT, WR_RESP
  } wr_state_t;

  // RO wins over W1C when both mask bits are set.
  function automatic acc_t acc_type(input logic [MAX_REGS-1:0] ro_mask,
                                    input logic [MAX_REGS-1:0] w1c_mask,
                                    input logic [7:0]          n);
    if (ro_mask[n])  return ACC_RO;
    if (w1c_mask[n]) return ACC_W1C;
    return ACC_RW;
  endfunction

endpackage

// File: rtl/vuprs_adc_reg_cell.sv
// One register of the file: byte-strobed RW update or W1C clear with hardware set.
module vuprs_adc_reg_cell
  import vuprs_adc_regs_pkg::*;
#(
  parameter int   DW  = 32,
  parameter acc_t ACC = ACC_RW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic [DW-1:0]   hw_set_i,
  output logic [DW-1:0]   q_o
);

  logic [DW-1:0] q_q, q_d, byte_mask;

  for (genvar k = 0; k < DW/8; k++) begin : g_mask
    assign byte_mask[k*8 +: 8] = {8{wstrb_i[k]}};
  end

  // For W1C the set is applied after the clear so a simultaneous set wins.
  always_comb begin
    q_d = q_q;
    case (ACC)
      ACC_RW: begin
        if (we_i) q_d = (q_q & ~byte_mask) | (wdata_i & byte_mask);
      end
      ACC_W1C: begin
        if (we_i) q_d = q_q & ~(wdata_i & byte_mask);
        q_d = q_d | hw_set_i;
      end
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/vuprs_adc_axil_regfile.sv
// AXI4-Lite slave register file for the ADC controller: per-register RW/RO/W1C
// access, byte strobes, SLVERR on bad targets, hardware status and write pulses.
module vuprs_adc_axil_regfile
  import vuprs_adc_regs_pkg::*;
#(
  parameter int                    C_S_AXI_DATA_WIDTH = 32,
  parameter int                    C_NUM_REGS         = 16,
  parameter int                    C_S_AXI_ADDR_WIDTH = 6,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK          = '0,
  parameter logic [C_NUM_REGS-1:0] C_W1C_MASK         = '0
) (
  input  logic                               S_AXI_ACLK,
  input  logic                               S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_status,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_set,
  output logic [C_NUM_REGS-1:0]              wr_pulse,
  output logic [2:0]                         dbg_wr_state_o
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int SW   = DW / 8;
  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int IDXW = $clog2(C_NUM_REGS);
  localparam int LSB  = $clog2(SW);
  localparam int HI   = IDXW + LSB;
  localparam logic [MAX_REGS-1:0] RO_EXT  = MAX_REGS'(C_RO_MASK);
  localparam logic [MAX_REGS-1:0] W1C_EXT = MAX_REGS'(C_W1C_MASK);

  wr_state_t        state_q, state_d;
  logic [AW-1:0]    aw_addr_q;
  logic [DW-1:0]    w_data_q;
  logic [SW-1:0]    w_strb_q;
  logic [1:0]       bresp_q;
  logic             rvalid_q;
  logic [DW-1:0]    rdata_q;
  logic [1:0]       rresp_q;

  acc_t             acc_a  [C_NUM_REGS];
  logic [DW-1:0]    regs_a [C_NUM_REGS];
  logic [DW-1:0]    stat_a [C_NUM_REGS];

  logic aw_full, w_full, bvalid, b_hs, awready, wready, aw_hs, w_hs;
  logic commit, w_oor, w_ok;
  logic [IDXW-1:0] w_idx, r_idx;
  logic ar_ready, ar_hs, r_oor;
  logic [DW-1:0] r_sel;
  logic unused_prot;

  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // Handshake: a beat transfers on a rising edge where VALID and READY are both
  // high. The AW/W holding slots stay full until the B handshake frees them, so
  // READY may reassert in the same cycle BVALID is accepted.
  assign aw_full = state_q inside {WR_HAVE_AW, WR_COMMIT, WR_RESP};
  assign w_full  = state_q inside {WR_HAVE_W, WR_COMMIT, WR_RESP};
  assign bvalid  = (state_q == WR_RESP);
  assign b_hs    = bvalid && S_AXI_BREADY;
  assign awready = !S_AXI_ARESET && (!aw_full || b_hs);
  assign wready  = !S_AXI_ARESET && (!w_full || b_hs);
  assign aw_hs   = S_AXI_AWVALID && awready;
  assign w_hs    = S_AXI_WVALID && wready;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) state_q <= WR_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_IDLE, WR_RESP: begin
        if (state_q == WR_IDLE || b_hs) begin
          if (aw_hs && w_hs) state_d = WR_COMMIT;
          else if (aw_hs)    state_d = WR_HAVE_AW;
          else if (w_hs)     state_d = WR_HAVE_W;
          else               state_d = WR_IDLE;
        end
      end
      WR_HAVE_AW: if (w_hs)  state_d = WR_COMMIT;
      WR_HAVE_W:  if (aw_hs) state_d = WR_COMMIT;
      WR_COMMIT:             state_d = WR_RESP;
      default:               state_d = WR_IDLE;
    endcase
  end

  // A commit pending when reset lands is dropped: no pulse, no register update.
  always_comb begin
    commit   = (state_q == WR_COMMIT) && !S_AXI_ARESET;
    w_oor    = (aw_addr_q >> HI) != '0;
    w_idx    = aw_addr_q[HI-1:LSB];
    w_ok     = !w_oor && (acc_a[w_idx] != ACC_RO);
    wr_pulse = '0;
    if (commit && w_ok) wr_pulse[w_idx] = 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs)  aw_addr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit) bresp_q <= w_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  for (genvar n = 0; n < C_NUM_REGS; n++) begin : g_reg
    localparam acc_t ACC = acc_type(RO_EXT, W1C_EXT, 8'(n));
    assign acc_a[n]  = ACC;
    assign regs_a[n] = reg_q[n*DW +: DW];
    assign stat_a[n] = hw_status[n*DW +: DW];

    vuprs_adc_reg_cell #(.DW(DW), .ACC(ACC)) u_cell (
      .clk_i    (S_AXI_ACLK),
      .rst_i    (S_AXI_ARESET),
      .we_i     (wr_pulse[n]),
      .wdata_i  (w_data_q),
      .wstrb_i  (w_strb_q),
      .hw_set_i (hw_set[n*DW +: DW]),
      .q_o      (reg_q[n*DW +: DW])
    );
  end

  // Reads sample the registered value, so a same-cycle write is not yet visible.
  assign ar_ready = !S_AXI_ARESET && (!rvalid_q || S_AXI_RREADY);
  assign ar_hs    = S_AXI_ARVALID && ar_ready;
  assign r_oor    = (S_AXI_ARADDR >> HI) != '0;
  assign r_idx    = S_AXI_ARADDR[HI-1:LSB];
  assign r_sel    = r_oor ? '0 : (acc_a[r_idx] == ACC_RO) ? stat_a[r_idx] : regs_a[r_idx];

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= r_sel;
      rresp_q  <= r_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_AWREADY  = awready;
  assign S_AXI_WREADY   = wready;
  assign S_AXI_BVALID   = bvalid;
  assign S_AXI_BRESP    = bresp_q;
  assign S_AXI_ARREADY  = ar_ready;
  assign S_AXI_RVALID   = rvalid_q;
  assign S_AXI_RDATA    = rdata_q;
  assign S_AXI_RRESP    = rresp_q;
  assign dbg_wr_state_o = state_q;

endmodule

// File: tb/tb_vuprs_adc_axil_regfile.sv
// Directed scoreboard bench for vuprs_adc_axil_regfile (16 x 32-bit, reg1 RO, reg3 W1C).
module tb_vuprs_adc_axil_regfile;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NR*DW-1:0] reg_q, hw_status, hw_set;
  logic [NR-1:0] wr_pulse;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail = 0;
  int pulse_cnt [NR];
  logic [1:0]    exp_b_q [$];
  logic [DW+1:0] exp_r_q [$];
  logic [DW-1:0] model [8];

  always #5 clk = ~clk;

  vuprs_adc_axil_regfile #(
    .C_S_AXI_DATA_WIDTH(DW), .C_NUM_REGS(NR), .C_S_AXI_ADDR_WIDTH(AW),
    .C_RO_MASK(16'h0002), .C_W1C_MASK(16'h0008)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q), .hw_status(hw_status), .hw_set(hw_set), .wr_pulse(wr_pulse),
    .dbg_wr_state_o(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every B and R handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int n = 0; n < NR; n++) if (wr_pulse[n]) pulse_cnt[n]++;
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected: got bresp %0h with no pending write", bresp);
        end else check("bresp", 64'(bresp), 64'(exp_b_q.pop_front()));
      end
      if (rvalid && rready) begin
        if (exp_r_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL r_unexpected: got rdata %0h with no pending read", rdata);
        end else begin
          logic [DW+1:0] e;
          e = exp_r_q.pop_front();
          check("rresp", 64'(rresp), 64'(e[DW+1:DW]));
          check("rdata", 64'(rdata), 64'(e[DW-1:0]));
        end
      end
    end
  end

  task automatic do_write_hs();
    logic aw_h, w_h;
    int c = 0;
    while ((awvalid || wvalid) && c < 50) begin
      @(negedge clk);
      aw_h = awvalid && awready;
      w_h  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_h) awvalid = 1'b0;
      if (w_h)  wvalid  = 1'b0;
      c++;
    end
    if (awvalid || wvalid) begin
      n_tests++; n_fail++;
      $display("FAIL write_hs_timeout: awvalid %0b wvalid %0b still pending, required handshake", awvalid, wvalid);
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] s, input logic [1:0] resp, input bit push);
    if (push) exp_b_q.push_back(resp);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    do_write_hs();
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] resp);
    int c = 0;
    logic h;
    exp_r_q.push_back({resp, d});
    araddr = a; arvalid = 1'b1;
    h = 1'b0;
    while (!h && c < 50) begin
      @(negedge clk); h = arready;
      @(posedge clk); #1;
      c++;
    end
    arvalid = 1'b0;
    if (!h) begin
      n_tests++; n_fail++;
      $display("FAIL read_hs_timeout: arready stayed 0, required 1");
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && c < 100) begin
      @(posedge clk); c++;
    end
    #1;
    if (exp_b_q.size() != 0 || exp_r_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d B and %0d R responses missing, required 0", exp_b_q.size(), exp_r_q.size());
      exp_b_q.delete(); exp_r_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, p2, beats, c;
    for (int n = 0; n < NR; n++) pulse_cnt[n] = 0;
    rst = 1'b1; bready = 1'b1; rready = 1'b1;
    awaddr = '0; awprot = 3'b010; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arprot = 3'b001; arvalid = 1'b0;
    hw_set = '0;
    for (int n = 0; n < NR; n++) hw_status[n*DW +: DW] = 32'hBAD0_0000 | 32'(n);
    hw_status[1*DW +: DW] = 32'hCAFE_0001;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 64'(awready), 0);
    check("rst_wready", 64'(wready), 0);
    check("rst_arready", 64'(arready), 0);
    check("rst_bvalid", 64'(bvalid), 0);
    check("rst_rvalid", 64'(rvalid), 0);
    check("rst_rdata", 64'(rdata), 0);
    check("rst_wr_pulse", 64'(wr_pulse), 0);
    check("rst_reg_q_zero", 64'(reg_q != '0), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Byte-strobed write over a prior value
    axi_write(8'h08, 32'h1122_3344, 4'hF, OKAY, 1);
    wait_drain();
    p = pulse_cnt[2];
    axi_write(8'h08, 32'hDEAD_BEEF, 4'b0101, OKAY, 1);
    wait_drain();
    check("t1_wr_pulse_cycles", 64'(pulse_cnt[2] - p), 1);
    check("t1_reg2", 64'(reg_q[2*DW +: DW]), 64'h11AD_33EF);
    axi_read(8'h08, 32'h11AD_33EF, OKAY);
    wait_drain();

    // W first, AW three cycles later, B back-pressured for 5 cycles
    bready = 1'b0;
    p = pulse_cnt[4]; p2 = pulse_cnt[5];
    exp_b_q.push_back(OKAY);
    wdata = 32'hA5A5_A5A5; wstrb = 4'hF; wvalid = 1'b1;
    do_write_hs();
    repeat (2) @(posedge clk);
    #1;
    awaddr = 8'h10; awvalid = 1'b1;
    do_write_hs();
    c = 0;
    while (!bvalid && c < 20) begin @(negedge clk); c++; end
    check("t2_bvalid_up", 64'(bvalid), 1);
    @(posedge clk); #1;
    exp_b_q.push_back(OKAY);
    awaddr = 8'h14; wdata = 32'h5A5A_1234; wstrb = 4'b1100;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_bvalid_held", 64'(bvalid), 1);
      check("t2_awready_blocked", 64'(awready), 0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    do_write_hs();
    wait_drain();
    check("t2_reg4_one_commit", 64'(pulse_cnt[4] - p), 1);
    check("t2_reg5_one_commit", 64'(pulse_cnt[5] - p2), 1);
    check("t2_reg4", 64'(reg_q[4*DW +: DW]), 64'hA5A5_A5A5);
    check("t2_reg5", 64'(reg_q[5*DW +: DW]), 64'h5A5A_0000);

    // W1C: clear with a simultaneous hardware set on bit 0
    hw_set[3*DW +: DW] = 32'hFF;
    @(posedge clk); #1;
    hw_set = '0;
    check("t3_w1c_set", 64'(reg_q[3*DW +: DW]), 64'hFF);
    axi_write(8'h0C, 32'h0000_000F, 4'hF, OKAY, 1);
    hw_set[3*DW +: DW] = 32'h01;
    @(posedge clk); #1;
    hw_set = '0;
    wait_drain();
    axi_read(8'h0C, 32'hF1, OKAY);
    wait_drain();

    // RO register
    p = pulse_cnt[1];
    axi_write(8'h04, 32'h0000_1234, 4'hF, SLVERR, 1);
    wait_drain();
    check("t4_ro_no_pulse", 64'(pulse_cnt[1] - p), 0);
    axi_read(8'h04, 32'hCAFE_0001, OKAY);
    wait_drain();

    // Out-of-range read, then 8 back-to-back reads
    axi_read(8'h40, 32'h0, SLVERR);
    wait_drain();
    model[0] = 32'h0;         model[1] = 32'hCAFE_0001;
    model[2] = 32'h11AD_33EF; model[3] = 32'hF1;
    model[4] = 32'hA5A5_A5A5; model[5] = 32'h5A5A_0000;
    model[6] = 32'h0;         model[7] = 32'h0;
    beats = 0;
    arvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      araddr = 8'(i * 4);
      exp_r_q.push_back({OKAY, model[i]});
      @(negedge clk);
      if (i > 0 && rvalid) beats++;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    @(negedge clk);
    if (rvalid) beats++;
    check("t5_b2b_beats", 64'(beats), 8);
    wait_drain();

    // Reset in the cycle after the AW/W handshake
    p = pulse_cnt[6];
    axi_write(8'h18, 32'h0000_0077, 4'hF, OKAY, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_no_pulse_in_reset", 64'(wr_pulse), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_bvalid", 64'(bvalid), 0);
    check("t6_reg6", 64'(reg_q[6*DW +: DW]), 0);
    check("t6_pulse", 64'(pulse_cnt[6] - p), 0);
    check("t6_state_idle", 64'(dbg_state), 0);
    check("t6_awready", 64'(awready), 1);
    @(posedge clk); #1;
    axi_read(8'h18, 32'h0, OKAY);
    axi_read(8'h08, 32'h0, OKAY);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
